i2s_sample_tx: RTL and testbench
================================

// Module: i2s_sample_tx
// PURPOSE
//  Audio-side consumer of the synth sample stream. Generates the per-frame sample
//  request strobe aud_freq that drives the synth, latches the synth's wave_out, and
//  serialises each sample MSB-first onto an I2S DAC link (BCLK/LRCLK/SDATA).
//  Mono source: the same sample is sent in both left and right slots.
//  All timing is derived from ctl_clk. There is no second clock domain.
// PARAMETERS
//  BITWIDTH    24  sample width. Must equal the synth BITWIDTH. Must be <= SLOT_WIDTH.
//  SLOT_WIDTH  32  BCLK periods per channel slot. A frame is 2*SLOT_WIDTH BCLKs.
//  BCLK_DIV    32  ctl_clk cycles per BCLK period. Must be even and >= 4.
// PORTS
//  ctl_clk     in   1         system clock
//  ctl_rst     in   1         reset, asynchronous, active-low
//  wave_in     in   BITWIDTH  two's-complement sample, connected to synth wave_out
//  enable      in   1         1 = transmit samples; 0 = mute (send zeros)
//  aud_freq    out  1         1-cycle sample request pulse, once per frame
//  i2s_bclk    out  1         serial bit clock
//  i2s_lrclk   out  1         word select: 0 = left slot, 1 = right slot
//  i2s_sdata   out  1         serial data; changes on BCLK fall, sampled on BCLK rise
// BEHAVIOUR
//  - Reset (ctl_rst=0) takes effect immediately. All outputs go to 0.
//    bclk_cnt, bit_cnt, shadow, shift and mute registers all clear to 0.
//  - bclk_cnt counts 0..BCLK_DIV-1 and then wraps to 0.
//    * fall_tick: the cycle where bclk_cnt==BCLK_DIV-1.
//    * rise_tick: the cycle where bclk_cnt==BCLK_DIV/2-1.
//  - All outputs are registered and update on the edge that ends a tick cycle:
//    * i2s_bclk goes to 0 on fall_tick and to 1 on rise_tick.
//    * Result: BCLK is low in the first half of each period, duty cycle 50%.
//  - bit_cnt counts 0..2*SLOT_WIDTH-1, advances on fall_tick, and wraps to 0.
//    * i2s_lrclk = (next bit_cnt >= SLOT_WIDTH).
//  - Frame start is the fall_tick on which bit_cnt wraps to 0. On that same edge:
//    * aud_freq is driven to 1 for exactly one ctl_clk cycle.
//    * The shadow register is copied into the left shift register, and mute <= ~enable.
//  - Latch point is the fall_tick on which bit_cnt becomes SLOT_WIDTH.
//    * wave_in is captured into the shadow register.
//    * The synth therefore has SLOT_WIDTH BCLK periods after aud_freq to settle wave_out.
//  - Right slot: at the latch point the right shift register also loads the shadow
//    value that was sent in the left slot. Both slots of a frame carry identical data.
//  - Latency: a sample requested at the start of frame N is latched mid-frame N and
//    transmitted in frame N+1.
//  - Slot data (standard I2S, one-BCLK delay):
//    * slot bit position p (0..SLOT_WIDTH-1): p=0 carries the last LSB/pad of the previous
//      slot; p=1..BITWIDTH carry sample MSB..LSB; p>BITWIDTH carry 0.
//    * i2s_sdata updates only on fall_tick.
//  - mute=1: every data bit of that frame is 0. Clocks and aud_freq keep running.
//  - A change on enable mid-frame takes effect only at the next frame start.
//  - A change on wave_in away from the latch-point edge is ignored.
//  - Reset asserted mid-frame aborts the frame. The block restarts from bit_cnt=0 with
//    a zero shadow. The first aud_freq occurs 2*SLOT_WIDTH*BCLK_DIV cycles after release.
//  - Elaboration: BITWIDTH>SLOT_WIDTH or an odd BCLK_DIV is a fatal $error.
// CONFIGURATION
//  - Macro I2S_LEFT_JUSTIFIED_EN.
//  - Defined: left-justified format with no one-BCLK delay.
//    * Sample MSB..LSB occupy p=0..BITWIDTH-1 and the rest are 0.
//    * i2s_lrclk is inverted (1 = left slot).
//    * Clock and aud_freq timing are unchanged.
//  - Undefined: standard I2S format as specified above.
// TESTING  (BITWIDTH=24, SLOT_WIDTH=32, BCLK_DIV=4, 10 ns ctl_clk)
//  1. ctl_rst=0 for 150 ns, then release.
//     -> all outputs 0 during reset.
//     -> after release: i2s_bclk period 4 clks at 50% duty; i2s_lrclk period 256 clks
//        with 128 clks at 0.
//  2. Free-run 4 frames.
//     -> aud_freq is high for exactly 1 cycle every 256 clks; first pulse 256 clks after
//        release, aligned to the i2s_lrclk 1->0 edge.
//  3. wave_in=24'hA5A5A5 held, enable=1.
//     -> in the next frame both slots show bits p1..p24 = A5A5A5 MSB-first and p25..p31 = 0.
//     -> bench samples data on the i2s_bclk rising edge.
//  4. wave_in switches 24'hA5A5A5->24'h800001 one cycle after a latch point.
//     -> the following frame still sends A5A5A5; 800001 appears one frame later.
//  5. enable=0 mid-frame.
//     -> current and next frame unchanged; the frame after that is all zeros.
//     -> aud_freq and the clocks are uninterrupted.
//     -> after enable returns to 1, data resumes at a frame boundary.
//  6. ctl_rst pulsed low mid-right-slot, asynchronous to ctl_clk.
//     -> outputs 0 in the same cycle.
//     -> after release, timing matches scenario 1.
//     -> with I2S_LEFT_JUSTIFIED_EN, the rerun of scenario 3 shows the MSB at p0 with
//        inverted lrclk.

Source files
------------

// File: rtl/i2s_sample_tx.sv
//============================================================================
// Module      : i2s_sample_tx
// Description : Audio-side sample consumer. Issues a once-per-frame sample
//               request (aud_freq), latches the synth sample mid-frame and
//               serialises it MSB-first onto an I2S DAC link. The source is
//               mono, so the same word goes out in the left and right slots.
//               Everything runs on ctl_clk; BCLK is a divided, registered
//               output.
//               Optional macro I2S_LEFT_JUSTIFIED_EN selects left-justified
//               framing (no one-BCLK data delay, lrclk high = left slot).
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module i2s_sample_tx #(
    parameter int BITWIDTH   = 24,
    parameter int SLOT_WIDTH = 32,
    parameter int BCLK_DIV   = 32
) (
    input  logic                ctl_clk,
    input  logic                ctl_rst,
    input  logic [BITWIDTH-1:0] wave_in,
    input  logic                enable,
    output logic                aud_freq,
    output logic                i2s_bclk,
    output logic                i2s_lrclk,
    output logic                i2s_sdata
);

    localparam int c_frame_bits  = 2 * SLOT_WIDTH;
    localparam int c_bit_cnt_w   = $clog2(c_frame_bits);
    localparam int c_bclk_cnt_w  = $clog2(BCLK_DIV);

    localparam logic [c_bclk_cnt_w-1:0] c_fall_cnt  = c_bclk_cnt_w'(BCLK_DIV - 1);
    localparam logic [c_bclk_cnt_w-1:0] c_rise_cnt  = c_bclk_cnt_w'(BCLK_DIV / 2 - 1);
    localparam logic [c_bclk_cnt_w-1:0] c_bclk_one  = c_bclk_cnt_w'(1);
    localparam logic [c_bit_cnt_w-1:0]  c_last_bit  = c_bit_cnt_w'(c_frame_bits - 1);
    localparam logic [c_bit_cnt_w-1:0]  c_last_left = c_bit_cnt_w'(SLOT_WIDTH - 1);
    localparam logic [c_bit_cnt_w-1:0]  c_slot_bits = c_bit_cnt_w'(SLOT_WIDTH);
    localparam logic [c_bit_cnt_w-1:0]  c_bit_one   = c_bit_cnt_w'(1);

    // Parameter sanity: a sample must fit in a slot and BCLK needs an exact 50% split.
    if (BITWIDTH > SLOT_WIDTH) begin : g_chk_width
        $error("i2s_sample_tx: BITWIDTH (%0d) exceeds SLOT_WIDTH (%0d)", BITWIDTH, SLOT_WIDTH);
    end
    if ((BCLK_DIV % 2) != 0 || BCLK_DIV < 4) begin : g_chk_div
        $error("i2s_sample_tx: BCLK_DIV (%0d) must be even and >= 4", BCLK_DIV);
    end

    // Registered state
    logic [c_bclk_cnt_w-1:0] bclk_cnt_q,    bclk_cnt_d;
    logic [c_bit_cnt_w-1:0]  bit_cnt_q,     bit_cnt_d;
    logic [BITWIDTH-1:0]     shadow_q,      shadow_d;
    logic [SLOT_WIDTH-1:0]   left_shift_q,  left_shift_d;
    logic [SLOT_WIDTH-1:0]   right_shift_q, right_shift_d;
    logic                    mute_q,        mute_d;
    logic                    delay_q,       delay_d;
    logic                    aud_freq_q,    aud_freq_d;
    logic                    bclk_q,        bclk_d;
    logic                    lrclk_q,       lrclk_d;
    logic                    sdata_q,       sdata_d;

    // Combinational helpers
    logic                    w_fall_tick;
    logic                    w_rise_tick;
    logic                    w_frame_start;
    logic                    w_latch_pt;
    logic                    w_right_slot;
    logic                    w_ser_bit;
    logic                    w_tx_bit;
    logic                    w_lrclk_next;
    logic [SLOT_WIDTH-1:0]   w_slot_word;
    logic [SLOT_WIDTH-1:0]   w_left_word;
    logic [SLOT_WIDTH-1:0]   w_right_word;
    logic [SLOT_WIDTH-1:0]   w_active_word;

    // Tick decode and frame/bit sequencing.
    always_comb begin
        w_fall_tick   = (bclk_cnt_q == c_fall_cnt);
        w_rise_tick   = (bclk_cnt_q == c_rise_cnt);
        w_frame_start = w_fall_tick && (bit_cnt_q == c_last_bit);
        w_latch_pt    = w_fall_tick && (bit_cnt_q == c_last_left);

        bclk_cnt_d = w_fall_tick ? '0 : (bclk_cnt_q + c_bclk_one);

        bit_cnt_d = bit_cnt_q;
        if (w_fall_tick) begin
            bit_cnt_d = w_frame_start ? '0 : (bit_cnt_q + c_bit_one);
        end

        // Position the new bit_cnt points at; slot select for data and lrclk.
        w_right_slot = (bit_cnt_d >= c_slot_bits);
    end

    // Slot word assembly and the per-slot shift registers.
    always_comb begin
        // Sample MSB-aligned in the slot, zero padding below the LSB.
        w_slot_word = '0;
        w_slot_word[SLOT_WIDTH-1 -: BITWIDTH] = shadow_q;

        // Left slot reloads at frame start, right slot at the latch point; both
        // take the pre-latch shadow so the two slots of a frame match.
        w_left_word   = w_frame_start ? w_slot_word : left_shift_q;
        w_right_word  = w_latch_pt    ? w_slot_word : right_shift_q;
        w_active_word = w_right_slot  ? w_right_word : w_left_word;
        w_ser_bit     = w_active_word[SLOT_WIDTH-1];

        left_shift_d  = left_shift_q;
        right_shift_d = right_shift_q;
        if (w_fall_tick) begin
            if (w_right_slot) begin
                right_shift_d = w_right_word << 1;
            end else begin
                left_shift_d  = w_left_word << 1;
            end
        end

        // One-bit history of the undelayed stream, used for the I2S delay.
        delay_d = w_fall_tick ? w_ser_bit : delay_q;
    end

    // Output-format selection and next values of the registered outputs.
    always_comb begin
`ifdef I2S_LEFT_JUSTIFIED_EN
        w_tx_bit     = w_ser_bit;
        w_lrclk_next = ~w_right_slot;
`else
        w_tx_bit     = delay_q;
        w_lrclk_next = w_right_slot;
`endif
        sdata_d = w_fall_tick ? w_tx_bit     : sdata_q;
        lrclk_d = w_fall_tick ? w_lrclk_next : lrclk_q;

        bclk_d = bclk_q;
        if (w_fall_tick) begin
            bclk_d = 1'b0;
        end else if (w_rise_tick) begin
            bclk_d = 1'b1;
        end

        aud_freq_d = w_frame_start;

        // Mute is sampled once per frame; it zeroes the sample latched in that
        // frame, so a change on enable reaches the link two frame starts later.
        mute_d   = w_frame_start ? ~enable : mute_q;
        shadow_d = shadow_q;
        if (w_latch_pt) begin
            shadow_d = mute_q ? '0 : wave_in;
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge ctl_clk or negedge ctl_rst) begin
        if (!ctl_rst) begin
            bclk_cnt_q    <= '0;
            bit_cnt_q     <= '0;
            shadow_q      <= '0;
            left_shift_q  <= '0;
            right_shift_q <= '0;
            mute_q        <= 1'b0;
            delay_q       <= 1'b0;
            aud_freq_q    <= 1'b0;
            bclk_q        <= 1'b0;
            lrclk_q       <= 1'b0;
            sdata_q       <= 1'b0;
        end else begin
            bclk_cnt_q    <= bclk_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shadow_q      <= shadow_d;
            left_shift_q  <= left_shift_d;
            right_shift_q <= right_shift_d;
            mute_q        <= mute_d;
            delay_q       <= delay_d;
            aud_freq_q    <= aud_freq_d;
            bclk_q        <= bclk_d;
            lrclk_q       <= lrclk_d;
            sdata_q       <= sdata_d;
        end
    end

    assign aud_freq  = aud_freq_q;
    assign i2s_bclk  = bclk_q;
    assign i2s_lrclk = lrclk_q;
    assign i2s_sdata = sdata_q;

endmodule

`default_nettype wire

// File: tb/tb_i2s_sample_tx.sv
//============================================================================
// Module      : tb_i2s_sample_tx
// Description : Directed self-checking bench for i2s_sample_tx with
//               BITWIDTH=24, SLOT_WIDTH=32, BCLK_DIV=4 on a 10 ns clock.
//               Frames are captured on BCLK rising edges (p0 at the MSB of
//               a 64-bit word) and compared to hand-built slot patterns.
//               Honours I2S_LEFT_JUSTIFIED_EN for the expected framing.
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_i2s_sample_tx;

    logic        ctl_clk;
    logic        ctl_rst;
    logic [23:0] wave_in;
    logic        enable;
    logic        aud_freq;
    logic        i2s_bclk;
    logic        i2s_lrclk;
    logic        i2s_sdata;

    int n_cmp    = 0;
    int n_err    = 0;
    int cyc      = 0;
    int rel_cyc  = 0;
    int last_aud = 0;

`ifdef I2S_LEFT_JUSTIFIED_EN
    localparam logic [63:0] c_exp_lr   = {32'hFFFF_FFFF, 32'h0000_0000};
    localparam int          c_lr_hi    = 124;
    localparam logic        c_right_lr = 1'b0;
`else
    localparam logic [63:0] c_exp_lr   = {32'h0000_0000, 32'hFFFF_FFFF};
    localparam int          c_lr_hi    = 128;
    localparam logic        c_right_lr = 1'b1;
`endif

    i2s_sample_tx #(
        .BITWIDTH   (24),
        .SLOT_WIDTH (32),
        .BCLK_DIV   (4)
    ) u_dut (
        .ctl_clk   (ctl_clk),
        .ctl_rst   (ctl_rst),
        .wave_in   (wave_in),
        .enable    (enable),
        .aud_freq  (aud_freq),
        .i2s_bclk  (i2s_bclk),
        .i2s_lrclk (i2s_lrclk),
        .i2s_sdata (i2s_sdata)
    );

    initial ctl_clk = 1'b0;
    always #5 ctl_clk = ~ctl_clk;

    // Free-running edge counter used as the time base for latency/period checks.
    always @(posedge ctl_clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected 64-bit frame (p0 first) for a mono sample.
    function automatic logic [63:0] exp_frame(input logic [23:0] s);
        logic [31:0] slot;
`ifdef I2S_LEFT_JUSTIFIED_EN
        slot = {s, 8'h00};
`else
        slot = {1'b0, s, 7'h00};
`endif
        return {slot, slot};
    endfunction

    task automatic step();
        @(posedge ctl_clk);
        #1;
    endtask

    task automatic wait_aud(output bit found, output int at_cyc);
        found  = 1'b0;
        at_cyc = 0;
        for (int n = 0; n < 400; n++) begin
            step();
            if (aud_freq) begin
                found  = 1'b1;
                at_cyc = cyc;
                break;
            end
        end
    endtask

    // Sample sdata/lrclk on the next 64 BCLK rising edges.
    task automatic capture_frame(output logic [63:0] d, output logic [63:0] lr);
        logic prev;
        int   n;
        d  = '0;
        lr = '0;
        for (int p = 0; p < 64; p++) begin
            n    = 0;
            prev = i2s_bclk;
            step();
            while (!(i2s_bclk && !prev) && n < 10) begin
                prev = i2s_bclk;
                step();
                n++;
            end
            d[63-p]  = i2s_sdata;
            lr[63-p] = i2s_lrclk;
        end
    endtask

    // One frame: request pulse timing, then the captured data and word select.
    // act: 0 none, 1 enable=0 mid-frame, 2 enable=1 with a new sample mid-frame,
    //      3 new sample one cycle after the latch point.
    task automatic frame_check(input string tag, input logic [23:0] s, input int act);
        bit          found;
        int          at;
        logic [63:0] d;
        logic [63:0] lr;
        wait_aud(found, at);
        check_eq({tag, "_aud_seen"}, 64'(found), 64'd1);
        check_eq({tag, "_aud_period"}, 64'(at - last_aud), 64'd256);
        last_aud = at;
        step();
        check_eq({tag, "_aud_width"}, 64'(aud_freq), 64'd0);
        fork
            capture_frame(d, lr);
            begin
                if (act != 0) begin
                    repeat ((act == 3) ? 128 : 99) @(posedge ctl_clk);
                    #2;
                    case (act)
                        1:       enable = 1'b0;
                        2:       begin enable = 1'b1; wave_in = 24'h3C0F96; end
                        default: wave_in = 24'h800001;
                    endcase
                end
            end
        join
        check_eq({tag, "_data"}, d, exp_frame(s));
        check_eq({tag, "_lrclk"}, lr, c_exp_lr);
    endtask

    initial begin
        int          e_bclk;
        int          e_lr;
        int          lr_hi;
        int          aud_hi;
        int          k;
        logic        eb;
        logic        el;
        logic [63:0] d;
        logic [63:0] lr;

        ctl_rst = 1'b0;
        enable  = 1'b1;
        wave_in = 24'hA5A5A5;

        // Reset state.
        #100;
        check_eq("rst_outputs", 64'({aud_freq, i2s_bclk, i2s_lrclk, i2s_sdata}), 64'd0);
        #50;
        ctl_rst  = 1'b1;
        rel_cyc  = cyc;
        last_aud = rel_cyc;

        // Clock waveforms over the first frame after release.
        e_bclk = 0; e_lr = 0; lr_hi = 0; aud_hi = 0;
        for (int i = 1; i < 256; i++) begin
            step();
            k  = cyc - rel_cyc;
            eb = ((k % 4) == 2) || ((k % 4) == 3);
`ifdef I2S_LEFT_JUSTIFIED_EN
            el = (k < 4) ? 1'b0 : !(((k / 4) % 64) >= 32);
`else
            el = ((k / 4) % 64) >= 32;
`endif
            if (i2s_bclk !== eb)  e_bclk++;
            if (i2s_lrclk !== el) e_lr++;
            if (i2s_lrclk)        lr_hi++;
            if (aud_freq)         aud_hi++;
        end
        check_eq("bclk_wave", 64'(e_bclk), 64'd0);
        check_eq("lrclk_wave", 64'(e_lr), 64'd0);
        check_eq("lrclk_hi_cnt", 64'(lr_hi), 64'(c_lr_hi));
        check_eq("aud_early", 64'(aud_hi), 64'd0);

        // Sample latched in the release frame goes out in frame 1.
        frame_check("f1", 24'hA5A5A5, 0);
        frame_check("f2", 24'hA5A5A5, 3);
        frame_check("f3", 24'hA5A5A5, 0);
        frame_check("f4", 24'h800001, 0);

        // Mute path: enable drops mid f5, zeros appear in f7; resume in f9.
        frame_check("f5", 24'h800001, 1);
        frame_check("f6", 24'h800001, 0);
        frame_check("f7", 24'h000000, 2);
        frame_check("f8", 24'h000000, 0);
        frame_check("f9", 24'h3C0F96, 0);

        // Asynchronous reset in the middle of a right slot.
        begin
            bit found;
            int at;
            wait_aud(found, at);
            check_eq("f10_aud_seen", 64'(found), 64'd1);
            repeat (180) step();
            check_eq("pre_rst_lrclk", 64'(i2s_lrclk), 64'(c_right_lr));
            #3;
            ctl_rst = 1'b0;
            #1;
            check_eq("rst_async_out", 64'({aud_freq, i2s_bclk, i2s_lrclk, i2s_sdata}), 64'd0);
            #26;
            ctl_rst  = 1'b1;
            rel_cyc  = cyc;
            last_aud = rel_cyc;
        end
        capture_frame(d, lr);
        check_eq("rst_f0_data", d, 64'd0);
        frame_check("r1", 24'h3C0F96, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Hard stop in case the run stalls.
    initial begin
        #200us;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
